// File: rtl/scan_seq_pkg.sv
// ---------------------------------------------------------------------------
// scan_seq_pkg
// Shared definitions for the 2-bit scan sequencer:
//   - scan_state_e      : sequencer state encoding (IDLE / ACTIVE / BLANK)
//   - DEFAULT_DWELL_W   : default width of the dwell count input
//   - DEFAULT_BLANK_W   : default width of the blank count input
//   - FIRST_ASC         : first select code of an ascending frame  (00)
//   - FIRST_DESC        : first select code of a descending frame  (11)
//   - max_width()       : helper used to size the shared timing counter
// ---------------------------------------------------------------------------
package scan_seq_pkg;

  localparam int DEFAULT_DWELL_W = 8;
  localparam int DEFAULT_BLANK_W = 4;

  localparam logic [1:0] FIRST_ASC  = 2'b00;
  localparam logic [1:0] FIRST_DESC = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } scan_state_e;

  function automatic int max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_down_counter.sv
// ---------------------------------------------------------------------------
// scan_down_counter
// Loadable down counter with a zero flag. Loading has priority over
// decrementing; the count saturates at zero.
// Ports:
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset, clears the count
//   i_load     : load i_load_val on the next edge
//   i_load_val : value to load (WIDTH bits)
//   i_dec      : decrement on the next edge when not loading
//   o_zero     : high while the count is zero
// ---------------------------------------------------------------------------
module scan_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/scan_sequencer_2b.sv
// ---------------------------------------------------------------------------
// scan_sequencer_2b
// Drives a downstream 2-to-4 decoder through the codes 00,01,10,11 (wrapping),
// holding each code for dwell+1 enabled cycles with an optional blank gap of
// `blank` disabled cycles between slots.
//
// Optional feature: define SCAN_DIR_EN to add the `dir` input. dir is sampled
// when scanning starts; dir=1 scans 11,10,01,00 (wrapping 00->11).
//
// Ports:
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start      : level request to begin scanning from IDLE
//   stop       : level request to abort scanning (priority over everything)
//   dir        : scan direction, only with SCAN_DIR_EN
//   dwell      : slot length minus one (DWELL_W bits), captured per slot
//   blank      : gap cycles between slots (BLANK_W bits), 0 = no gap
//   w          : decoder select code
//   en         : decoder enable
//   slot_done  : final ACTIVE cycle of each slot
//   frame_done : final ACTIVE cycle of the last code in the sequence
//   busy       : sequencer is not IDLE
// ---------------------------------------------------------------------------
module scan_sequencer_2b
  import scan_seq_pkg::*;
#(
  parameter int DWELL_W = DEFAULT_DWELL_W,
  parameter int BLANK_W = DEFAULT_BLANK_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
`ifdef SCAN_DIR_EN
  input  logic               dir,
`endif
  input  logic [DWELL_W-1:0] dwell,
  input  logic [BLANK_W-1:0] blank,
  output logic [1:0]         w,
  output logic               en,
  output logic               slot_done,
  output logic               frame_done,
  output logic               busy
);

  // One counter times both the dwell and the blank phases, so it must hold
  // the wider of the two counts.
  localparam int CNT_W = max_width(DWELL_W, BLANK_W);

  scan_state_e r_state;
  scan_state_e w_state_nxt;
  logic [1:0]  r_code;
  logic [1:0]  w_code_nxt;

  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_zero;

  logic       w_desc;
  logic [1:0] w_first_code;
  logic [1:0] w_next_code;
  logic [1:0] w_last_code;
  logic       w_active;
  logic       w_slot_end;

`ifdef SCAN_DIR_EN
  logic r_dir;
  logic w_dir_nxt;

  // Direction is latched at the start of a frame so a moving dir input
  // cannot reverse a scan in progress.
  assign w_desc       = r_dir;
  assign w_first_code = dir ? FIRST_DESC : FIRST_ASC;
`else
  assign w_desc       = 1'b0;
  assign w_first_code = FIRST_ASC;
`endif

  assign w_next_code = w_desc ? (r_code - 2'd1) : (r_code + 2'd1);
  assign w_last_code = w_desc ? FIRST_ASC : FIRST_DESC;

  scan_down_counter #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_code  <= FIRST_ASC;
`ifdef SCAN_DIR_EN
      r_dir   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
`ifdef SCAN_DIR_EN
      r_dir   <= w_dir_nxt;
`endif
    end
  end

  // Next-state logic. The counter is loaded with dwell on every ACTIVE entry
  // and with blank-1 on BLANK entry, so a zero count always marks the last
  // cycle of the current phase. Stop is tested first in both busy states.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_cnt_val   = '0;
`ifdef SCAN_DIR_EN
    w_dir_nxt   = r_dir;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_state_nxt = ST_ACTIVE;
          w_code_nxt  = w_first_code;
          w_cnt_load  = 1'b1;
          w_cnt_val   = CNT_W'(dwell);
`ifdef SCAN_DIR_EN
          w_dir_nxt   = dir;
`endif
        end
      end
      ST_ACTIVE: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_code_nxt  = FIRST_ASC;
          w_cnt_load  = 1'b1;
        end else if (w_cnt_zero) begin
          if (blank == '0) begin
            w_code_nxt = w_next_code;
            w_cnt_load = 1'b1;
            w_cnt_val  = CNT_W'(dwell);
          end else begin
            w_state_nxt = ST_BLANK;
            w_cnt_load  = 1'b1;
            w_cnt_val   = CNT_W'(blank) - CNT_W'(1);
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_BLANK: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_code_nxt  = FIRST_ASC;
          w_cnt_load  = 1'b1;
        end else if (w_cnt_zero) begin
          w_state_nxt = ST_ACTIVE;
          w_code_nxt  = w_next_code;
          w_cnt_load  = 1'b1;
          w_cnt_val   = CNT_W'(dwell);
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_code_nxt  = FIRST_ASC;
        w_cnt_load  = 1'b1;
      end
    endcase
  end

  assign w_active   = (r_state == ST_ACTIVE);
  assign w_slot_end = w_active && w_cnt_zero;

  assign w          = r_code;
  assign en         = w_active;
  assign busy       = (r_state != ST_IDLE);
  assign slot_done  = w_slot_end;
  assign frame_done = w_slot_end && (r_code == w_last_code);

endmodule

// File: tb/tb_scan_sequencer_2b.sv
// ---------------------------------------------------------------------------
// tb_scan_sequencer_2b
// Self-checking bench for scan_sequencer_2b. A table of per-cycle vectors
// covers the basic scan, gaps, wrap, start/stop interaction; hand-written
// sequences cover stop mid-slot, asynchronous reset mid-gap, dwell changes
// mid-slot and (with SCAN_DIR_EN) descending scans.
// ---------------------------------------------------------------------------
module tb_scan_sequencer_2b;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic [7:0] dwell;
  logic [3:0] blank;
  logic [1:0] w;
  logic       en;
  logic       slot_done;
  logic       frame_done;
  logic       busy;
`ifdef SCAN_DIR_EN
  logic       dir;
`endif

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    logic       start;
    logic       stop;
    logic [7:0] dwell;
    logic [3:0] blank;
    logic [1:0] expW;
    logic       expEn;
    logic       expSlot;
    logic       expFrame;
    logic       expBusy;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  scan_sequencer_2b #(
    .DWELL_W (8),
    .BLANK_W (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
`ifdef SCAN_DIR_EN
    .dir        (dir),
`endif
    .dwell      (dwell),
    .blank      (blank),
    .w          (w),
    .en         (en),
    .slot_done  (slot_done),
    .frame_done (frame_done),
    .busy       (busy)
  );

  task automatic addVec(input logic st, input logic sp, input logic [7:0] dw,
                        input logic [3:0] bl, input logic [1:0] ew,
                        input logic een, input logic esd, input logic efd,
                        input logic ebusy);
    vec_t v;
    v.start = st;   v.stop = sp;    v.dwell = dw;   v.blank = bl;
    v.expW = ew;    v.expEn = een;  v.expSlot = esd;
    v.expFrame = efd; v.expBusy = ebusy;
    vecs.push_back(v);
  endtask

  // Drive inputs on the falling edge, let one rising edge pass, then settle.
  task automatic applyStimulus(input logic st, input logic sp,
                               input logic [7:0] dw, input logic [3:0] bl);
    @(negedge clk);
    start = st;
    stop  = sp;
    dwell = dw;
    blank = bl;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] ew,
                             input logic een, input logic esd, input logic efd,
                             input logic ebusy);
    nChecks++;
    if ({w, en, slot_done, frame_done, busy} === {ew, een, esd, efd, ebusy}) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got w=%b en=%b slot=%b frame=%b busy=%b, expected w=%b en=%b slot=%b frame=%b busy=%b",
               name, w, en, slot_done, frame_done, busy, ew, een, esd, efd, ebusy);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    nChecks++;
    if (actual == expected) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    logic [1:0] wSeq [12];
    int cnt0;
    int cnt1;
    bit sawSlot;

    reset_n = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    dwell   = 8'd0;
    blank   = 4'd0;
`ifdef SCAN_DIR_EN
    dir     = 1'b0;
`endif
    #1;
    checkOutput("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd2, 4'd0);
    checkOutput("idleAfterReset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // dwell=2, blank=0: each code for 3 cycles, start held high throughout
    addVec(1, 0, 2, 0, 2'd0, 1, 0, 0, 1);
    addVec(1, 0, 2, 0, 2'd0, 1, 0, 0, 1);
    addVec(1, 0, 2, 0, 2'd0, 1, 1, 0, 1);
    addVec(1, 0, 2, 0, 2'd1, 1, 0, 0, 1);
    addVec(1, 0, 2, 0, 2'd1, 1, 0, 0, 1);
    addVec(1, 0, 2, 0, 2'd1, 1, 1, 0, 1);
    addVec(1, 0, 2, 0, 2'd2, 1, 0, 0, 1);
    addVec(1, 0, 2, 0, 2'd2, 1, 0, 0, 1);
    addVec(1, 0, 2, 0, 2'd2, 1, 1, 0, 1);
    addVec(1, 0, 2, 0, 2'd3, 1, 0, 0, 1);
    addVec(1, 0, 2, 0, 2'd3, 1, 0, 0, 1);
    addVec(1, 0, 2, 0, 2'd3, 1, 1, 1, 1);
    addVec(1, 0, 2, 0, 2'd0, 1, 0, 0, 1);
    addVec(1, 1, 2, 0, 2'd0, 0, 0, 0, 0);
    addVec(1, 1, 2, 0, 2'd0, 0, 0, 0, 0);
    addVec(0, 0, 2, 0, 2'd0, 0, 0, 0, 0);
    // dwell=0, blank=2: en 1,0,0 repeating, code advances after each gap
    addVec(1, 0, 0, 2, 2'd0, 1, 1, 0, 1);
    addVec(0, 0, 0, 2, 2'd0, 0, 0, 0, 1);
    addVec(0, 0, 0, 2, 2'd0, 0, 0, 0, 1);
    addVec(0, 0, 0, 2, 2'd1, 1, 1, 0, 1);
    addVec(0, 0, 0, 2, 2'd1, 0, 0, 0, 1);
    addVec(0, 0, 0, 2, 2'd1, 0, 0, 0, 1);
    addVec(0, 0, 0, 2, 2'd2, 1, 1, 0, 1);
    addVec(0, 0, 0, 2, 2'd2, 0, 0, 0, 1);
    addVec(0, 0, 0, 2, 2'd2, 0, 0, 0, 1);
    addVec(0, 0, 0, 2, 2'd3, 1, 1, 1, 1);
    addVec(0, 0, 0, 2, 2'd3, 0, 0, 0, 1);
    addVec(0, 0, 0, 2, 2'd3, 0, 0, 0, 1);
    addVec(0, 0, 0, 2, 2'd0, 1, 1, 0, 1);
    addVec(0, 1, 0, 2, 2'd0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].dwell, vecs[i].blank);
      checkOutput($sformatf("vec%0d", i), vecs[i].expW, vecs[i].expEn,
                  vecs[i].expSlot, vecs[i].expFrame, vecs[i].expBusy);
    end

    // Stop raised in the 2nd cycle of the w=01 slot
    applyStimulus(1'b1, 1'b0, 8'd2, 4'd0);
    checkOutput("stopSeqStart", 2'd0, 1, 0, 0, 1);
    applyStimulus(1'b0, 1'b0, 8'd2, 4'd0);
    applyStimulus(1'b0, 1'b0, 8'd2, 4'd0);
    sawSlot = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd2, 4'd0);
    checkOutput("stopSeqW1c1", 2'd1, 1, 0, 0, 1);
    sawSlot = sawSlot | slot_done;
    applyStimulus(1'b0, 1'b0, 8'd2, 4'd0);
    checkOutput("stopSeqW1c2", 2'd1, 1, 0, 0, 1);
    sawSlot = sawSlot | slot_done;
    applyStimulus(1'b0, 1'b1, 8'd2, 4'd0);
    checkOutput("stopSeqIdle", 2'd0, 0, 0, 0, 0);
    sawSlot = sawSlot | slot_done;
    checkValue("stopSeqNoSlotDone", int'(sawSlot), 0);
    applyStimulus(1'b0, 1'b0, 8'd2, 4'd0);
    checkOutput("stopSeqStaysIdle", 2'd0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of the w=01 gap
    applyStimulus(1'b1, 1'b0, 8'd0, 4'd3);
    checkOutput("rstSeqActive", 2'd0, 1, 1, 0, 1);
    applyStimulus(1'b0, 1'b0, 8'd0, 4'd3);
    checkOutput("rstSeqBlank0", 2'd0, 0, 0, 0, 1);
    repeat (3) applyStimulus(1'b0, 1'b0, 8'd0, 4'd3);
    applyStimulus(1'b0, 1'b0, 8'd0, 4'd3);
    checkOutput("rstSeqBlank1", 2'd1, 0, 0, 0, 1);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("rstSeqAsync", 2'd0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd2, 4'd0);
    checkOutput("rstSeqIdle1", 2'd0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 8'd2, 4'd0);
    checkOutput("rstSeqIdle2", 2'd0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 8'd2, 4'd0);

    // Dwell changed from 2 to 5 while the first slot is running
    applyStimulus(1'b1, 1'b0, 8'd2, 4'd0);
    wSeq[0] = w;
    for (int i = 1; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 8'd5, 4'd0);
      wSeq[i] = w;
    end
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 12; i++) begin
      if (wSeq[i] == 2'd0) cnt0++;
      if (wSeq[i] == 2'd1) cnt1++;
    end
    checkValue("dwellChgSlot0Len", cnt0, 3);
    checkValue("dwellChgSlot1Len", cnt1, 6);
    checkValue("dwellChgSlot2Start", int'(wSeq[9]), 2);
    applyStimulus(1'b0, 1'b1, 8'd2, 4'd0);
    checkOutput("dwellChgStop", 2'd0, 0, 0, 0, 0);

`ifdef SCAN_DIR_EN
    // Descending scan, dwell=1; dir dropped after start must not matter
    begin
      logic [1:0] expW   [8] = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd3};
      logic       expSd  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic       expFd  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      @(negedge clk);
      dir = 1'b1;
      applyStimulus(1'b1, 1'b0, 8'd1, 4'd0);
      checkOutput("dirStart", 2'd3, 1, 0, 0, 1);
      dir = 1'b0;
      for (int i = 0; i < 8; i++) begin
        applyStimulus(1'b0, 1'b0, 8'd1, 4'd0);
        checkOutput($sformatf("dirStep%0d", i), expW[i], 1'b1, expSd[i], expFd[i], 1'b1);
      end
      applyStimulus(1'b0, 1'b1, 8'd1, 4'd0);
      checkOutput("dirStop", 2'd0, 0, 0, 0, 0);
    end
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/scan_sequencer_2b.md
SCAN_SEQUENCER_2B -- requirements
Module: scan_sequencer_2b

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, which is the width of the dwell count input.
REQ-002 SHALL have parameter BLANK_W, default 4, which is the width of the blank count input.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit, a level request to begin scanning from IDLE.
REQ-006 SHALL have port stop, input, 1 bit, a level request to abort scanning and return to IDLE.
REQ-007 SHALL have port dwell, input, DWELL_W bits; each select slot lasts dwell+1 cycles.
REQ-008 SHALL have port blank, input, BLANK_W bits, the number of enable-low gap cycles between slots (0 means no gap).
REQ-009 SHALL have port w, output, 2 bits, the select code for a downstream 2-to-4 decoder.
REQ-010 SHALL have port en, output, 1 bit, the enable for the downstream decoder.
REQ-011 SHALL have port slot_done, output, 1 bit, high during the final ACTIVE cycle of every slot.
REQ-012 SHALL have port frame_done, output, 1 bit, high during the final ACTIVE cycle of the last code in the sequence.
REQ-013 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ACTIVE and BLANK; all outputs SHALL be decoded from registers only.
REQ-015 IDLE: en=0, w=00, busy=0; start=1 sampled at an edge SHALL give ACTIVE, w=00, en=1 from that edge.
REQ-016 On every ACTIVE entry, dwell SHALL be loaded into the down counter; changes to dwell mid-slot SHALL have no effect until the next slot.
REQ-017 ACTIVE SHALL hold w constant with en=1 for exactly dwell+1 cycles; dwell=0 SHALL give a 1-cycle slot.
REQ-018 At the end of a slot, if blank=0, the block SHALL enter ACTIVE with the next code on the next cycle, and en SHALL stay 1.
REQ-019 At the end of a slot, if blank>0, the block SHALL enter BLANK for exactly blank cycles with en=0 and w held, then enter ACTIVE with the next code.
REQ-020 The code sequence SHALL be 00,01,10,11 and wrap 11->00 with no idle cycle.
REQ-021 frame_done SHALL coincide with slot_done for code 11 (ascending) or code 00 (descending).
REQ-022 stop=1 sampled at an edge in ACTIVE or BLANK SHALL give IDLE at that edge (en=0, w=00); stop SHALL have priority over start and over slot completion.
REQ-023 start while busy SHALL be ignored; start and stop held together in IDLE SHALL leave the block in IDLE.
REQ-024 start held high continuously SHALL NOT restart the frame; scanning SHALL continue until stop.

Reset
REQ-025 reset_n=0 SHALL immediately force IDLE, w=00, en=0, slot_done=0, frame_done=0, busy=0, and counter=0, regardless of the clock.
REQ-026 On reset release, the block SHALL stay in IDLE until start is sampled high.

Configuration
REQ-027 With macro SCAN_DIR_EN defined, the block SHALL have port dir, input, 1 bit; dir is sampled at IDLE->ACTIVE; dir=1 SHALL give the sequence 11,10,01,00 with wrap 00->11, starting at 11.
REQ-028 Without SCAN_DIR_EN, the dir port SHALL be absent and the sequence SHALL be ascending only.

Structure
REQ-029 Package scan_seq_pkg SHALL hold the state enum type, the default widths, and the code constants FIRST_ASC=00 and FIRST_DESC=11.
REQ-030 Sub-module scan_down_counter (loadable down counter with zero flag, parameterised width) SHALL serve both the dwell and blank timing.

Verification
REQ-031 The bench SHALL cover: reset, then start=1 with dwell=2, blank=0 -> w=00,01,10,11 each for 3 cycles with en=1 throughout; frame_done is 1 cycle on the 12th active cycle.
REQ-032 The bench SHALL cover: dwell=0, blank=2 -> en pattern 1,0,0 repeating; w increments after each gap; 11 wraps to 00.
REQ-033 The bench SHALL cover: stop asserted in the 2nd cycle of the w=01 slot -> next edge IDLE, en=0, w=00, busy=0; slot_done is never asserted for that slot.
REQ-034 The bench SHALL cover: reset_n pulled low mid-BLANK, between clock edges -> outputs are 0 immediately, before the next edge.
REQ-035 The bench SHALL cover: dwell changed from 2 to 5 mid-slot -> the current slot still lasts 3 cycles and the next slot lasts 6.
REQ-036 With SCAN_DIR_EN, the bench SHALL cover: dir=1 with dwell=1 -> w=11,10,01,00,11, each for 2 cycles; frame_done occurs on the 00 slot.
